// File: rtl/md_sequencer.sv
// Multiply/divide sequencer owning HI/LO: result commits MULT_CYCLES/DIV_CYCLES edges after start.
// No backpressure input; md_stall holds D-stage HI/LO users until the in-flight result is committed.
module md_sequencer #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  e_md_op,
   input  logic [31:0] e_a,
   input  logic [31:0] e_b,
   input  logic        d_is_md,
   output logic        md_stall,
   output logic        busy,
   output logic [31:0] rd_data,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {IDLE, BUSY} state_e;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] res_hi_q, res_hi_d;
   logic [31:0] res_lo_q, res_lo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        is_mul, is_div, start;
   logic [63:0] prod_s, prod_u;
   logic [31:0] calc_hi, calc_lo;

   assign is_mul = (e_md_op == OP_MULT) || (e_md_op == OP_MULTU);
   assign is_div = (e_md_op == OP_DIV)  || (e_md_op == OP_DIVU);
   assign busy   = (state_q == BUSY);
   assign start  = (state_q == IDLE) && (is_mul || is_div);

   assign md_stall = d_is_md && (busy || start);
   assign hi       = hi_q;
   assign lo       = lo_q;

   always_comb begin
      rd_data = '0;
      if (e_md_op == OP_MFHI) begin
         rd_data = hi_q;
      end else if (e_md_op == OP_MFLO) begin
         rd_data = lo_q;
      end
   end

   assign prod_s = $signed({{32{e_a[31]}}, e_a}) * $signed({{32{e_b[31]}}, e_b});
   assign prod_u = {32'd0, e_a} * {32'd0, e_b};

   // Divide by zero latches the current HI/LO so the commit leaves them unchanged.
   always_comb begin
      calc_hi = hi_q;
      calc_lo = lo_q;
      case (e_md_op)
         OP_MULT:  {calc_hi, calc_lo} = prod_s;
         OP_MULTU: {calc_hi, calc_lo} = prod_u;
         OP_DIV: begin
            if (e_b != 32'd0) begin
               if ((e_a == 32'h8000_0000) && (e_b == 32'hFFFF_FFFF)) begin
                  calc_lo = e_a;
                  calc_hi = 32'd0;
               end else begin
                  calc_lo = $signed(e_a) / $signed(e_b);
                  calc_hi = $signed(e_a) % $signed(e_b);
               end
            end
         end
         OP_DIVU: begin
            if (e_b != 32'd0) begin
               calc_lo = e_a / e_b;
               calc_hi = e_a % e_b;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = BUSY;
               cnt_d    = is_div ? DIV_N : MULT_N;
               res_hi_d = calc_hi;
               res_lo_d = calc_lo;
            end else if (e_md_op == OP_MTHI) begin
               hi_d = e_a;
            end else if (e_md_op == OP_MTLO) begin
               lo_d = e_a;
            end
         end
         BUSY: begin
            // Anything presented in E while busy is ignored.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = IDLE;
               hi_d    = res_hi_q;
               lo_d    = res_lo_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

endmodule
